// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Captures one byte per wr_valid pulse into a circular FIFO and serves it
// first-word-fall-through over a valid/ready handshake. Reports occupancy and
// a sticky overrun flag.
// Optional feature macro: UART_RXF_OVERWRITE_EN
//   undefined: a write into a full FIFO (no pop that cycle) is dropped.
//   defined:   such a write overwrites the oldest entry instead.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic push, pop, ovf, mem_we;

  // Status and head-of-queue outputs
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FullCount);
    rd_valid = !empty;
    rd_data  = mem[rd_ptr_q];
    count    = count_q;
    overrun  = overrun_q;
  end

  // Handshake decode; a pop frees the slot an incoming byte needs when full
  always_comb begin
    pop  = rd_ready & rd_valid;
    push = wr_valid & (!full | pop);
    ovf  = wr_valid & full & !pop;
  end

  // Next-state for pointers, occupancy and the sticky overrun flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;

    if (push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef UART_RXF_OVERWRITE_EN
    // Oldest entry is discarded: both pointers step, occupancy stays at DEPTH
    if (ovf) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
`endif

    // Set wins over clear in the same cycle
    if (ovf) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; not reset, writes suppressed during reset
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
// Honours UART_RXF_OVERWRITE_EN the same way the design does.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overrun;
  logic              clr_overrun;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: ordered byte queue plus sticky flag
  logic [DATA_W-1:0] mq[$];
  logic              m_ovr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic wv, input logic [DATA_W-1:0] wd,
                            input logic rr, input logic clr);
    bit was_full, do_pop, do_ovf;
    if (r) begin
      mq.delete();
      m_ovr = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    do_pop   = rr && (mq.size() != 0);
    do_ovf   = wv && was_full && !do_pop;
    if (do_pop) void'(mq.pop_front());
    if (wv && (!was_full || do_pop)) mq.push_back(wd);
`ifdef UART_RXF_OVERWRITE_EN
    if (do_ovf) begin
      void'(mq.pop_front());
      mq.push_back(wd);
    end
`endif
    if (do_ovf) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_all();
    check_eq("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    check_eq("empty",    32'(empty),    32'(mq.size() == 0));
    check_eq("full",     32'(full),     32'(mq.size() == DEPTH));
    check_eq("count",    32'(count),    32'(mq.size()));
    check_eq("overrun",  32'(overrun),  32'(m_ovr));
    if (mq.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(mq[0]));
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later
  task automatic cycle(input logic r, input logic wv, input logic [DATA_W-1:0] wd,
                       input logic rr, input logic clr);
    rst         = r;
    wr_valid    = wv;
    wr_data     = wd;
    rd_ready    = rr;
    clr_overrun = clr;
    @(posedge clk);
    model_step(r, wv, wd, rr, clr);
    #1;
    check_all();
  endtask

  task automatic fill_seq();
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
  endtask

  // Drains the FIFO (bounded) and returns the last byte seen at the head
  task automatic drain(output logic [DATA_W-1:0] last);
    last = '0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (mq.size() == 0) break;
      last = rd_data;
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("drain_empty", 32'(empty), 32'd1);
  endtask

  logic [DATA_W-1:0] last_b;
  int unsigned       rd_pct;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_overrun = 1'b0;
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("reset_empty", 32'(empty), 32'd1);
    check_eq("reset_rd_valid", 32'(rd_valid), 32'd0);

    // Single byte, one-cycle write-to-read latency
    cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("t1_data", 32'(rd_data), 32'hA5);
    check_eq("t1_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("t1_count0", 32'(count), 32'd0);

    // Fill and read back in order across the pointer wrap
    fill_seq();
    check_eq("t2_full", 32'(full), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      check_eq("t2_order", 32'(rd_data), 32'(i));
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("t2_empty", 32'(empty), 32'd1);

    // Overflow without a read
    fill_seq();
    cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    check_eq("t3_overrun", 32'(overrun), 32'd1);
    check_eq("t3_count", 32'(count), 32'd16);
`ifdef UART_RXF_OVERWRITE_EN
    check_eq("t3_head", 32'(rd_data), 32'h01);
    drain(last_b);
    check_eq("t3_last", 32'(last_b), 32'h55);
`else
    check_eq("t3_head", 32'(rd_data), 32'h00);
    drain(last_b);
    check_eq("t3_last", 32'(last_b), 32'h0F);
`endif
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("t3_clr", 32'(overrun), 32'd0);

    // Full with simultaneous read and write
    fill_seq();
    cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("t4_overrun", 32'(overrun), 32'd0);
    check_eq("t4_count", 32'(count), 32'd16);
    check_eq("t4_head", 32'(rd_data), 32'h01);
    drain(last_b);
    check_eq("t4_last", 32'(last_b), 32'h77);
    // Empty with both asserted: write only
    cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    check_eq("t4_empty_count", 32'(count), 32'd1);
    check_eq("t4_empty_data", 32'(rd_data), 32'h3C);
    drain(last_b);

    // Overrun set beats clear
    fill_seq();
    cycle(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hE2, 1'b0, 1'b1);
    check_eq("t5_set_wins", 32'(overrun), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_clr", 32'(overrun), 32'd0);
    drain(last_b);

    // Reset mid-stream discards everything and ignores the concurrent write
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hF1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_eq("t6_count", 32'(count), 32'd0);
    check_eq("t6_overrun", 32'(overrun), 32'd0);

    // Randomized traffic in phases with different read pressure
    for (int ph = 0; ph < 8; ph++) begin
      rd_pct = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 50 : (ph % 4 == 2) ? 90 : 30;
      for (int i = 0; i < 300; i++) begin
        cycle(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 60),
              8'($urandom),
              ($urandom_range(0, 99) < rd_pct),
              ($urandom_range(0, 19) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
